// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master to 1-slave arbiter for the SOPC bus.
// Picks one requesting master (round-robin or fixed priority) and forwards its
// address/read/write/data_wr/mask to the slave in the same cycle. A stalled
// transaction locks the bus to its owner until it completes, is aborted, or
// (optionally) times out. A timeout forces a release and sets a sticky flag.
//
// Ports:
//   clk          clock bundle: clk.base = clock, clk.rst = sync active-high reset
//   m_address    per-master address            m_read / m_write  per-master request
//   m_data_wr    per-master write data         m_mask            per-master byte mask
//   m_stall      per-master stall
//   m_data_rd    slave read data, broadcast    m_data_rd_2       second read word, broadcast
//   s_address / s_read / s_write / s_data_wr / s_mask   forwarded to the slave
//   s_stall / s_data_rd / s_data_rd_2                    from the slave
//   grant        one-hot current owner (0 when idle)
//   timeout_err  sticky, set when a hung slave access is forcibly released

package bus_arbiter_rr_pkg;
  typedef struct packed {
    logic base;
    logic rst;
  } Clock_t;
endpackage

module bus_arbiter_rr #(
  parameter int N_MASTERS  = 2,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 0
) (
  input  bus_arbiter_rr_pkg::Clock_t         clk,
  input  logic [N_MASTERS-1:0][31:0]         m_address,
  input  logic [N_MASTERS-1:0]               m_read,
  input  logic [N_MASTERS-1:0]               m_write,
  input  logic [N_MASTERS-1:0][31:0]         m_data_wr,
  input  logic [N_MASTERS-1:0][3:0]          m_mask,
  output logic [N_MASTERS-1:0]               m_stall,
  output logic [31:0]                        m_data_rd,
  output logic [31:0]                        m_data_rd_2,
  output logic [31:0]                        s_address,
  output logic                               s_read,
  output logic                               s_write,
  output logic [31:0]                        s_data_wr,
  output logic [3:0]                         s_mask,
  input  logic                               s_stall,
  input  logic [31:0]                        s_data_rd,
  input  logic [31:0]                        s_data_rd_2,
  output logic [N_MASTERS-1:0]               grant,
  output logic                               timeout_err
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]           state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     owner;
  logic [CNT_W-1:0]     cnt;

  logic [N_MASTERS-1:0] req;
  logic                 found;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     sel;
  logic                 active;
  logic                 force_release;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N_MASTERS - 1)) return '0;
    return i + IDX_W'(1);
  endfunction

  assign req         = m_read | m_write;
  assign m_data_rd   = s_data_rd;
  assign m_data_rd_2 = s_data_rd_2;

  // First requester scanning upward from ptr (or from 0 under fixed priority).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (FIXED_PRIO != 0) cand = IDX_W'(k);
      else                 cand = IDX_W'((32'(ptr) + k) % N_MASTERS);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign sel    = (state == LOCKED) ? owner : winner;
  assign active = !clk.rst && ((state == LOCKED) || found);

  // Hung owner: released in the cycle its lock counter reaches TIMEOUT.
  assign force_release = (TIMEOUT != 0) && (state == LOCKED) && req[owner] &&
                         s_stall && (cnt == CNT_W'(TIMEOUT));

  // Requesting non-owners stall, idle masters never do; the forwarded master
  // follows the slave unless a timeout release overrides it.
  always_comb begin
    m_stall   = req;
    grant     = '0;
    s_address = '0;
    s_read    = 1'b0;
    s_write   = 1'b0;
    s_data_wr = '0;
    s_mask    = '0;
    if (active) begin
      grant[sel]   = 1'b1;
      s_address    = m_address[sel];
      s_read       = m_read[sel];
      s_write      = m_write[sel];
      s_data_wr    = m_data_wr[sel];
      s_mask       = m_mask[sel];
      m_stall[sel] = req[sel] && s_stall && !force_release;
    end
  end

  always_ff @(posedge clk.base) begin
    if (clk.rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else if (state == IDLE) begin
      if (found) begin
        if (!s_stall) begin
          ptr <= next_idx(winner);
        end else begin
          owner <= winner;
          cnt   <= CNT_W'(1);
          state <= LOCKED;
        end
      end
    end else begin
      if (!req[owner] || !s_stall) begin
        // Completion or abort both hand the bus on.
        ptr   <= next_idx(owner);
        state <= IDLE;
      end else if (force_release) begin
        timeout_err <= 1'b1;
        ptr         <= next_idx(owner);
        state       <= IDLE;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

  logic clk_base;
  logic rst;
  bus_arbiter_rr_pkg::Clock_t clk_s;
  assign clk_s.base = clk_base;
  assign clk_s.rst  = rst;

  logic [2:0][31:0] m_address;
  logic [2:0]       m_read;
  logic [2:0]       m_write;
  logic [2:0][31:0] m_data_wr;
  logic [2:0][3:0]  m_mask;
  logic             s_stall;
  logic [31:0]      s_data_rd;
  logic [31:0]      s_data_rd_2;

  // Round-robin DUT: 3 masters, timeout 8
  logic [2:0]  stall_rr, grant_rr;
  logic [31:0] drd_rr, drd2_rr, saddr_rr, swdat_rr;
  logic        srd_rr, swr_rr, terr_rr;
  logic [3:0]  smask_rr;

  // Fixed-priority DUT: 2 masters, no timeout
  logic [1:0]  stall_fp, grant_fp;
  logic [31:0] drd_fp, drd2_fp, saddr_fp, swdat_fp;
  logic        srd_fp, swr_fp, terr_fp;
  logic [3:0]  smask_fp;

  bus_arbiter_rr #(.N_MASTERS(3), .FIXED_PRIO(0), .TIMEOUT(8)) dut_rr (
    .clk(clk_s), .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_data_wr(m_data_wr), .m_mask(m_mask), .m_stall(stall_rr),
    .m_data_rd(drd_rr), .m_data_rd_2(drd2_rr), .s_address(saddr_rr),
    .s_read(srd_rr), .s_write(swr_rr), .s_data_wr(swdat_rr), .s_mask(smask_rr),
    .s_stall(s_stall), .s_data_rd(s_data_rd), .s_data_rd_2(s_data_rd_2),
    .grant(grant_rr), .timeout_err(terr_rr)
  );

  bus_arbiter_rr #(.N_MASTERS(2), .FIXED_PRIO(1), .TIMEOUT(0)) dut_fp (
    .clk(clk_s), .m_address(m_address[1:0]), .m_read(m_read[1:0]),
    .m_write(m_write[1:0]), .m_data_wr(m_data_wr[1:0]), .m_mask(m_mask[1:0]),
    .m_stall(stall_fp), .m_data_rd(drd_fp), .m_data_rd_2(drd2_fp),
    .s_address(saddr_fp), .s_read(srd_fp), .s_write(swr_fp),
    .s_data_wr(swdat_fp), .s_mask(smask_fp), .s_stall(s_stall),
    .s_data_rd(s_data_rd), .s_data_rd_2(s_data_rd_2),
    .grant(grant_fp), .timeout_err(terr_fp)
  );

  initial begin
    clk_base = 1'b0;
    forever #5 clk_base = ~clk_base;
  end

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural reference ----------------
  typedef struct packed {
    bit locked;
    int ptr;
    int owner;
    int cnt;
    bit terr;
  } mstate_t;

  typedef struct packed {
    logic [2:0]  grant;
    logic [2:0]  stall;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdat;
    logic [3:0]  mask;
  } out_t;

  mstate_t st_rr, st_fp;

  function automatic bit rq(int i);
    return m_read[i] | m_write[i];
  endfunction

  // Requester at the smallest rotational distance from the priority origin.
  function automatic int pick(mstate_t s, int n, bit fixed);
    int best, bestd, origin, d;
    best = -1; bestd = n;
    origin = fixed ? 0 : s.ptr;
    for (int i = 0; i < n; i++) begin
      d = (i - origin + n) % n;
      if (rq(i) && d < bestd) begin
        bestd = d; best = i;
      end
    end
    return best;
  endfunction

  function automatic out_t model_out(mstate_t s, int n, bit fixed, int tmo);
    out_t o;
    int sel;
    o = '0;
    for (int i = 0; i < n; i++) o.stall[i] = rq(i);
    if (rst) return o;
    sel = s.locked ? s.owner : pick(s, n, fixed);
    if (sel < 0) return o;
    o.grant[sel] = 1'b1;
    o.addr = m_address[sel];
    o.rd   = m_read[sel];
    o.wr   = m_write[sel];
    o.wdat = m_data_wr[sel];
    o.mask = m_mask[sel];
    o.stall[sel] = rq(sel) && s_stall && !(s.locked && tmo != 0 && s.cnt == tmo);
    return o;
  endfunction

  function automatic mstate_t model_next(mstate_t s, int n, bit fixed, int tmo);
    mstate_t ns;
    int w;
    ns = s;
    if (rst) begin
      ns = '0;
      return ns;
    end
    if (!s.locked) begin
      w = pick(s, n, fixed);
      if (w >= 0) begin
        if (!s_stall) ns.ptr = (w + 1) % n;
        else begin
          ns.locked = 1'b1; ns.owner = w; ns.cnt = 1;
        end
      end
    end else if (!rq(s.owner) || !s_stall) begin
      ns.locked = 1'b0; ns.ptr = (s.owner + 1) % n;
    end else if (tmo != 0 && s.cnt == tmo) begin
      ns.locked = 1'b0; ns.ptr = (s.owner + 1) % n; ns.terr = 1'b1;
    end else begin
      ns.cnt = s.cnt + 1;
    end
    return ns;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    out_t o;
    o = model_out(st_rr, 3, 1'b0, 8);
    chk("rr_grant", 32'(grant_rr), 32'(o.grant));
    chk("rr_stall", 32'(stall_rr), 32'(o.stall));
    chk("rr_saddr", saddr_rr, o.addr);
    chk("rr_sread", 32'(srd_rr), 32'(o.rd));
    chk("rr_swrite", 32'(swr_rr), 32'(o.wr));
    chk("rr_sdatawr", swdat_rr, o.wdat);
    chk("rr_smask", 32'(smask_rr), 32'(o.mask));
    chk("rr_terr", 32'(terr_rr), 32'(st_rr.terr));
    chk("rr_drd", drd_rr, s_data_rd);
    chk("rr_drd2", drd2_rr, s_data_rd_2);
    o = model_out(st_fp, 2, 1'b1, 0);
    chk("fp_grant", 32'(grant_fp), 32'(o.grant[1:0]));
    chk("fp_stall", 32'(stall_fp), 32'(o.stall[1:0]));
    chk("fp_saddr", saddr_fp, o.addr);
    chk("fp_sread", 32'(srd_fp), 32'(o.rd));
    chk("fp_swrite", 32'(swr_fp), 32'(o.wr));
    chk("fp_sdatawr", swdat_fp, o.wdat);
    chk("fp_smask", 32'(smask_fp), 32'(o.mask));
    chk("fp_terr", 32'(terr_fp), 32'(st_fp.terr));
    chk("fp_drd", drd_fp, s_data_rd);
    chk("fp_drd2", drd2_fp, s_data_rd_2);
  endtask

  // Called at a negedge with inputs already set; the model advances on the edge.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk_base);
    st_rr = model_next(st_rr, 3, 1'b0, 8);
    st_fp = model_next(st_fp, 2, 1'b1, 0);
    @(negedge clk_base);
  endtask

  task automatic set_req(input logic [2:0] rd, input logic [2:0] wr, input logic stall);
    m_read  = rd;
    m_write = wr;
    s_stall = stall;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(3'b000, 3'b000, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    st_rr = '0;
    st_fp = '0;
    for (int i = 0; i < 3; i++) begin
      m_address[i] = 32'h1000 * (i + 1);
      m_data_wr[i] = 32'hA000_0000 + i;
      m_mask[i]    = 4'hF;
    end
    m_read = '0; m_write = '0;
    s_stall = 1'b0; s_data_rd = 32'h1234_5678; s_data_rd_2 = 32'h9ABC_DEF0;
    @(negedge clk_base);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    set_req(3'b000, 3'b000, 1'b0);
    #1;
    chk("lit_reset_grant", 32'(grant_rr), 32'h0);
    chk("lit_reset_terr", 32'(terr_rr), 32'h0);
    tick();

    // Two readers, no stall: M0 then M1
    set_req(3'b011, 3'b000, 1'b0);
    #1;
    chk("lit_t1_grant0", 32'(grant_rr), 32'h1);
    chk("lit_t1_stall0", 32'(stall_rr), 32'h2);
    tick();
    set_req(3'b010, 3'b000, 1'b0);
    #1;
    chk("lit_t1_grant1", 32'(grant_rr), 32'h2);
    chk("lit_t1_stall1", 32'(stall_rr), 32'h0);
    tick();

    // Stalled write locks bus to M0 while M1 waits
    do_reset();
    m_address[0] = 32'h0000_0010;
    set_req(3'b000, 3'b001, 1'b1);
    #1;
    chk("lit_t2_grant_c0", 32'(grant_rr), 32'h1);
    chk("lit_t2_saddr", saddr_rr, 32'h0000_0010);
    chk("lit_t2_swrite", 32'(swr_rr), 32'h1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      set_req(3'b010, 3'b001, (c == 3) ? 1'b0 : 1'b1);
      #1;
      chk("lit_t2_grant_lock", 32'(grant_rr), 32'h1);
      chk("lit_t2_m1_stall", 32'(stall_rr[1]), 32'h1);
      tick();
    end
    set_req(3'b010, 3'b000, 1'b0);
    #1;
    chk("lit_t2_grant_c4", 32'(grant_rr), 32'h2);
    chk("lit_t2_sread_c4", 32'(srd_rr), 32'h1);
    tick();

    // All request continuously: rr rotates, fp always M0
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_req(3'b111, 3'b000, 1'b0);
      #1;
      chk("lit_t3_rr_grant", 32'(grant_rr), 32'(3'b001 << (c % 3)));
      chk("lit_t6_fp_grant", 32'(grant_fp), 32'h1);
      chk("lit_t6_fp_stall", 32'(stall_fp), 32'h2);
      tick();
    end

    // Hung slave: forced release in the 8th locked cycle
    do_reset();
    m_address[0] = 32'h1000;
    set_req(3'b001, 3'b000, 1'b1);
    tick();
    for (int c = 1; c <= 8; c++) begin
      set_req(3'b011, 3'b000, 1'b1);
      #1;
      chk("lit_t4_stall", 32'(stall_rr), (c == 8) ? 32'h2 : 32'h3);
      chk("lit_t4_terr_pre", 32'(terr_rr), 32'h0);
      tick();
    end
    set_req(3'b011, 3'b000, 1'b1);
    #1;
    chk("lit_t4_terr_set", 32'(terr_rr), 32'h1);
    chk("lit_t4_next_grant", 32'(grant_rr), 32'h2);
    tick();

    // Reset while locked on M1
    rst = 1'b1;
    set_req(3'b011, 3'b000, 1'b1);
    #1;
    chk("lit_t5_rst_grant", 32'(grant_rr), 32'h0);
    chk("lit_t5_rst_sread", 32'(srd_rr), 32'h0);
    chk("lit_t5_rst_stall", 32'(stall_rr), 32'h3);
    tick();
    rst = 1'b0;
    set_req(3'b000, 3'b000, 1'b1);
    #1;
    chk("lit_t5_idle_grant", 32'(grant_rr), 32'h0);
    chk("lit_t5_terr_clr", 32'(terr_rr), 32'h0);
    tick();
    set_req(3'b011, 3'b000, 1'b0);
    #1;
    chk("lit_t5_ptr0", 32'(grant_rr), 32'h1);
    tick();

    // Randomised traffic with periodic slave hangs and occasional resets
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit hang;
      hang = (cyc % 60) >= 45;
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 99) < (hang ? 95 : 60)) begin
          m_read[i]  = $urandom_range(0, 1);
          m_write[i] = ~m_read[i];
        end else begin
          m_read[i]  = 1'b0;
          m_write[i] = 1'b0;
        end
        m_address[i] = $urandom;
        m_data_wr[i] = $urandom;
        m_mask[i]    = 4'($urandom_range(0, 15));
      end
      s_stall     = hang ? 1'b1 : ($urandom_range(0, 2) == 0);
      s_data_rd   = $urandom;
      s_data_rd_2 = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
